// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: state encodings and
// default parameter values used by pc_unit and its next-PC selector.
package pc_unit_pkg;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int          DEF_XLEN         = 64;
  localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;
  localparam logic [63:0] DEF_TRAP_VECTOR  = 64'h100;
  localparam int          DEF_INC          = 4;
  localparam int          DEF_ALIGN_BITS   = 2;

endpackage

// File: rtl/pc_unit_next_sel.sv
// Combinational next-PC selector: applies the trap / mret / redirect / halt /
// sequential priority and reports EPC capture and misaligned-target events.
module pc_unit_next_sel
  import pc_unit_pkg::*;
#(
  parameter int              XLEN        = DEF_XLEN,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEF_TRAP_VECTOR),
  parameter int              INC         = DEF_INC,
  parameter int              ALIGN_BITS  = DEF_ALIGN_BITS
) (
  input  logic [1:0]      state,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] epc,
  input  logic            trap,
  input  logic            mret,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] next_pc,
  output logic [1:0]      next_state,
  output logic            epc_we,
  output logic            misaligned_next
);

  // Mask form keeps ALIGN_BITS = 0 legal (no alignment constraint).
  localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN_BITS);
  localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);

  logic target_misaligned;
  logic in_run;
  logic in_halt;

  assign target_misaligned = (redirect_target & ALIGN_MASK) != '0;
  assign in_run            = (state == ST_RUN);
  assign in_halt           = (state == ST_HALT);

  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // priority chain leaves a signal unassigned and infers a latch.
    next_pc         = pc;
    next_state      = state;
    epc_we          = 1'b0;
    misaligned_next = 1'b0;

    if (state == ST_BOOT) begin
      next_state = ST_RUN;
    end else if (in_run || in_halt) begin
      if (trap) begin
        epc_we     = 1'b1;
        next_pc    = TRAP_VECTOR;
        next_state = ST_RUN;
      end else if (in_halt && resume) begin
        next_state = ST_RUN;
      end else if (mret) begin
        next_pc = epc;
      end else if (redirect_valid) begin
        if (target_misaligned) begin
          epc_we          = 1'b1;
          next_pc         = TRAP_VECTOR;
          misaligned_next = 1'b1;
        end else begin
          next_pc = redirect_target;
        end
      end else if (in_run && halt_req) begin
        next_state = ST_HALT;
      end else if (in_run && fetch_ready) begin
        next_pc = pc + INC_W;
      end
    end else begin
      // Unused encoding recovers through BOOT.
      next_state = ST_BOOT;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC, EPC and BOOT/RUN/HALT state and
// offers the PC to fetch over a valid/ready handshake.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              INC          = DEF_INC,
  parameter int              ALIGN_BITS   = DEF_ALIGN_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic            mret,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic            halted
);

  logic [1:0]      state;
  logic [1:0]      next_state;
  logic [XLEN-1:0] next_pc;
  logic            epc_we;
  logic            misaligned_next;

  pc_unit_next_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INC         (INC),
    .ALIGN_BITS  (ALIGN_BITS)
  ) u_next_sel (
    .state           (state),
    .pc              (pc),
    .epc             (epc),
    .trap            (trap),
    .mret            (mret),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .resume          (resume),
    .fetch_ready     (fetch_ready),
    .next_pc         (next_pc),
    .next_state      (next_state),
    .epc_we          (epc_we),
    .misaligned_next (misaligned_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values (epc captures the old pc, not next_pc).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_BOOT;
      pc         <= RESET_VECTOR;
      epc        <= '0;
      misaligned <= 1'b0;
    end else if (enable) begin
      state      <= next_state;
      pc         <= next_pc;
      misaligned <= misaligned_next;
      if (epc_we) begin
        epc <= pc;
      end
    end else begin
      // Frozen cycle: everything holds, but a pending pulse must not linger.
      misaligned <= 1'b0;
    end
  end

  assign pc_valid = (state == ST_RUN);
  assign halted   = (state == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random stimulus,
// checked through a scoreboard fed by a behavioural model of the PC rules.
module tb_pc_unit;

  localparam logic [63:0] TRAP_PC = 64'h100;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        trap;
  logic        mret;
  logic        halt_req;
  logic        resume;
  logic [63:0] pc;
  logic        pc_valid;
  logic [63:0] epc;
  logic        misaligned;
  logic        halted;

  pc_unit dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .fetch_ready     (fetch_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .mret            (mret),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .epc             (epc),
    .misaligned      (misaligned),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {M_BOOT, M_RUN, M_HALT} mode_t;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] epc;
    logic        valid;
    logic        halted;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];

  mode_t       m_mode;
  logic [63:0] m_pc;
  logic [63:0] m_epc;
  logic        m_mis;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = M_BOOT;
    m_pc   = 64'h0;
    m_epc  = 64'h0;
    m_mis  = 1'b0;
  endtask

  // Apply one cycle of inputs and predict the state after the coming edge.
  task automatic drive(input bit en, input bit fr, input bit rv, input logic [63:0] tgt,
                       input bit tr, input bit mr, input bit hr, input bit rs);
    exp_t e;
    enable          = en;
    fetch_ready     = fr;
    redirect_valid  = rv;
    redirect_target = tgt;
    trap            = tr;
    mret            = mr;
    halt_req        = hr;
    resume          = rs;

    m_mis = 1'b0;
    if (en) begin
      if (m_mode == M_BOOT) begin
        m_mode = M_RUN;
      end else if (tr) begin
        m_epc  = m_pc;
        m_pc   = TRAP_PC;
        m_mode = M_RUN;
      end else if (m_mode == M_HALT && rs) begin
        m_mode = M_RUN;
      end else if (mr) begin
        m_pc = m_epc;
      end else if (rv && (tgt % 4) != 0) begin
        m_epc = m_pc;
        m_pc  = TRAP_PC;
        m_mis = 1'b1;
      end else if (rv) begin
        m_pc = tgt;
      end else if (m_mode == M_RUN && hr) begin
        m_mode = M_HALT;
      end else if (m_mode == M_RUN && fr) begin
        m_pc = m_pc + 64'd4;
      end
    end

    e.pc     = m_pc;
    e.epc    = m_epc;
    e.valid  = (m_mode == M_RUN);
    e.halted = (m_mode == M_HALT);
    e.mis    = m_mis;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input bit en, input bit fr, input bit rv, input logic [63:0] tgt,
                     input bit tr, input bit mr, input bit hr, input bit rs);
    @(negedge clk);
    drive(en, fr, rv, tgt, tr, mr, hr, rs);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic rand_cycle();
    logic [63:0] tgt;
    case ($urandom_range(0, 3))
      0: tgt = m_pc + 64'($urandom_range(0, 63));
      1: tgt = {$urandom, $urandom} & ~64'h3;
      2: tgt = {$urandom, $urandom};
      default: tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
    endcase
    cyc($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 60,
        $urandom_range(0, 99) < 15, tgt,
        $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5,
        $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 20);
  endtask

  // Monitor: the DUT presents a new output set after every edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_epc", epc, e.epc);
        check("sb_pc_valid", 64'(pc_valid), 64'(e.valid));
        check("sb_halted", 64'(halted), 64'(e.halted));
        check("sb_misaligned", 64'(misaligned), 64'(e.mis));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    reset           = 1'b0;
    enable          = 1'b0;
    fetch_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 64'h0;
    trap            = 1'b0;
    mret            = 1'b0;
    halt_req        = 1'b0;
    resume          = 1'b0;
    model_reset();

    #50;
    reset = 1'b1;
    check("rst_pc", pc, 64'h0);
    check("rst_pc_valid", 64'(pc_valid), 64'h0);
    check("rst_epc", epc, 64'h0);
    check("rst_halted", 64'(halted), 64'h0);
    check("rst_misaligned", 64'(misaligned), 64'h0);
    drive(1, 0, 0, 64'h0, 0, 0, 0, 0);
    settle();
    check("boot_pc_valid", 64'(pc_valid), 64'h1);
    check("boot_pc", pc, 64'h0);

    // Sequential fetch, hold, and enable freeze.
    cyc(1, 1, 0, 64'h0, 0, 0, 0, 0);
    cyc(1, 1, 0, 64'h0, 0, 0, 0, 0);
    cyc(1, 1, 0, 64'h0, 0, 0, 0, 0);
    settle();
    check("seq_pc12", pc, 64'hC);
    cyc(1, 0, 0, 64'h0, 0, 0, 0, 0);
    cyc(0, 1, 1, 64'h80, 1, 0, 1, 0);
    settle();
    check("freeze_pc", pc, 64'hC);

    // Redirect flushes the handshake; misaligned target traps.
    cyc(1, 0, 1, 64'h8, 0, 0, 0, 0);
    cyc(1, 1, 1, 64'h40, 0, 0, 0, 0);
    settle();
    check("redir_pc", pc, 64'h40);
    cyc(1, 0, 1, 64'h8, 0, 0, 0, 0);
    cyc(1, 1, 1, 64'h42, 0, 0, 0, 0);
    settle();
    check("misal_pc", pc, 64'h100);
    check("misal_epc", epc, 64'h8);
    check("misal_pulse", 64'(misaligned), 64'h1);
    cyc(1, 0, 0, 64'h0, 0, 0, 0, 0);
    settle();
    check("misal_clear", 64'(misaligned), 64'h0);

    // Trap beats redirect; mret returns to epc.
    cyc(1, 0, 1, 64'h40, 0, 0, 0, 0);
    cyc(1, 1, 1, 64'h80, 1, 0, 0, 0);
    settle();
    check("trap_pc", pc, 64'h100);
    check("trap_epc", epc, 64'h40);
    cyc(1, 1, 0, 64'h0, 0, 1, 0, 0);
    settle();
    check("mret_pc", pc, 64'h40);

    // Halt freezes fetch; resume beats a concurrent halt_req.
    cyc(1, 1, 0, 64'h0, 0, 0, 1, 0);
    settle();
    check("halt_halted", 64'(halted), 64'h1);
    check("halt_pc_valid", 64'(pc_valid), 64'h0);
    cyc(1, 1, 0, 64'h0, 0, 0, 1, 0);
    cyc(1, 1, 0, 64'h0, 0, 0, 0, 0);
    settle();
    check("halt_pc_frozen", pc, 64'h40);
    cyc(1, 1, 0, 64'h0, 0, 0, 1, 1);
    settle();
    check("resume_pc_valid", 64'(pc_valid), 64'h1);
    check("resume_pc", pc, 64'h40);

    // Wrap at the top of the address space.
    cyc(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
    cyc(1, 1, 0, 64'h0, 0, 0, 0, 0);
    settle();
    check("wrap_pc", pc, 64'h0);

    for (int i = 0; i < 3000; i++) rand_cycle();

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_rst_pc", pc, 64'h0);
    check("async_rst_epc", epc, 64'h0);
    check("async_rst_pc_valid", 64'(pc_valid), 64'h0);
    check("async_rst_halted", 64'(halted), 64'h0);
    check("async_rst_misaligned", 64'(misaligned), 64'h0);
    enable         = 1'b1;
    fetch_ready    = 1'b1;
    redirect_valid = 1'b1;
    trap           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_pc", pc, 64'h0);
    check("rst_held_pc_valid", 64'(pc_valid), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1, 0, 64'h0, 0, 0, 0, 0);

    for (int i = 0; i < 1000; i++) rand_cycle();

    settle();
    check("sb_drained", 64'(sb_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
